// File: rtl/expansion_input_filter_pkg.sv
// Shared constants and helpers for the RIO expansion input path.
// Defaults here are reused by the expander instantiation.
package rio_expansion_pkg;

  localparam int EXP_TICK_DIV = 1000;
  localparam int EXP_DEBOUNCE = 4;

  // Ceiling log2, never below 1 so single-value counters still get a bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/expansion_input_filter_if.sv
// Bundle of expander input, enable/clear controls and filtered event outputs.
interface expansion_input_filter_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] event_clr;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] change_strobe;
  logic [WIDTH-1:0] rise_flag;
  logic [WIDTH-1:0] fall_flag;
  logic             irq;

  modport master (
    output raw_in, rise_en, fall_en, event_clr,
    input  filtered, change_strobe, rise_flag, fall_flag, irq
  );

  modport slave (
    input  raw_in, rise_en, fall_en, event_clr,
    output filtered, change_strobe, rise_flag, fall_flag, irq
  );

endinterface

// File: rtl/expansion_input_filter_debounce.sv
// One-bit tick-sampled debouncer: the level must differ for DEBOUNCE
// consecutive ticks before the filtered output follows.
module expansion_debounce_bit
  import rio_expansion_pkg::*;
#(
  parameter int   DEBOUNCE  = EXP_DEBOUNCE,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sync,
  input  logic i_tick,
  output logic o_filtered,
  output logic o_change,
  output logic o_rise_set,
  output logic o_fall_set
);

  localparam int CNT_W = clog2(DEBOUNCE);

  logic [CNT_W-1:0] r_cnt;
  logic             r_filtered;
  logic             r_change;
  logic             w_differ;
  logic             w_commit;

  assign w_differ = (i_sync != r_filtered);
  assign w_commit = i_tick && w_differ && (r_cnt == CNT_W'(DEBOUNCE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_filtered <= RESET_BIT;
      r_change   <= 1'b0;
    end else begin
      r_change <= w_commit;
      if (i_tick) begin
        // A matching sample restarts the count, which is what rejects glitches.
        if (!w_differ) begin
          r_cnt <= '0;
        end else if (w_commit) begin
          r_filtered <= i_sync;
          r_cnt      <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_filtered = r_filtered;
  assign o_change   = r_change;
  assign o_rise_set = w_commit & i_sync;
  assign o_fall_set = w_commit & ~i_sync;

endmodule

// File: rtl/expansion_input_filter.sv
// Synchronizes and debounces expander inputs, then raises sticky edge flags
// and a maskable, registered interrupt for the register interface.
module expansion_input_filter
  import rio_expansion_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               TICK_DIV    = EXP_TICK_DIV,
  parameter int               DEBOUNCE    = EXP_DEBOUNCE,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                     clk,
  input logic                     rst,
  expansion_input_filter_if.slave bus
);

  localparam int TICK_W = clog2(TICK_DIV);

  logic [WIDTH-1:0]  r_sync1;
  logic [WIDTH-1:0]  r_sync2;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;
  logic [WIDTH-1:0]  w_filtered;
  logic [WIDTH-1:0]  w_change;
  logic [WIDTH-1:0]  w_rise_set;
  logic [WIDTH-1:0]  w_fall_set;
  logic [WIDTH-1:0]  r_rise_flag;
  logic [WIDTH-1:0]  r_fall_flag;
  logic              r_irq;

  // raw_in comes from the slow I2C domain; only r_sync2 is used past here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= RESET_VALUE;
      r_sync2 <= RESET_VALUE;
    end else begin
      r_sync1 <= bus.raw_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    expansion_debounce_bit #(
      .DEBOUNCE  (DEBOUNCE),
      .RESET_BIT (RESET_VALUE[gi])
    ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .i_sync     (r_sync2[gi]),
      .i_tick     (w_tick),
      .o_filtered (w_filtered[gi]),
      .o_change   (w_change[gi]),
      .o_rise_set (w_rise_set[gi]),
      .o_fall_set (w_fall_set[gi])
    );
  end

  // Set is OR-ed in after the clear so a coincident new edge survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise_flag <= '0;
      r_fall_flag <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_rise_flag <= (r_rise_flag & ~bus.event_clr) | w_rise_set;
      r_fall_flag <= (r_fall_flag & ~bus.event_clr) | w_fall_set;
      r_irq       <= |((r_rise_flag & bus.rise_en) | (r_fall_flag & bus.fall_en));
    end
  end

  assign bus.filtered      = w_filtered;
  assign bus.change_strobe = w_change;
  assign bus.rise_flag     = r_rise_flag;
  assign bus.fall_flag     = r_fall_flag;
  assign bus.irq           = r_irq;

endmodule

// File: tb/tb_expansion_input_filter.sv
// Directed bench for expansion_input_filter with a strobe scoreboard.
module tb_expansion_input_filter;

  localparam int W  = 8;
  localparam int TD = 4;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  expansion_input_filter_if #(.WIDTH(W)) bus ();

  expansion_input_filter #(
    .WIDTH       (W),
    .TICK_DIV    (TD),
    .DEBOUNCE    (DB),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the DUT tick fires on edges that are multiples of TD.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int         at;
    logic [7:0] strb;
    logic [7:0] filt;
    logic [7:0] rise;
    logic [7:0] fall;
  } exp_t;

  exp_t       q[$];
  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] exp_filt = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.change_strobe != 8'h00) begin
      exp_t e;
      if (q.size() == 0) begin
        check("unexpected_strobe", {24'd0, bus.change_strobe}, 32'd0);
      end else begin
        e = q.pop_front();
        check("strobe_cycle", cyc, e.at);
        check("strobe_mask", {24'd0, bus.change_strobe}, {24'd0, e.strb});
        check("strobe_filtered", {24'd0, bus.filtered}, {24'd0, e.filt});
        check("strobe_rise", {24'd0, bus.rise_flag & e.strb}, {24'd0, e.rise});
        check("strobe_fall", {24'd0, bus.fall_flag & e.strb}, {24'd0, e.fall});
      end
    end
  end

  task automatic wait_to(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Called at a negedge; returns the edge count at which filtered must change.
  task automatic drive(input logic [7:0] v, output int at);
    int   n0;
    int   e1;
    exp_t e;
    n0 = cyc;
    e1 = ((n0 + 3 + TD - 1) / TD) * TD;
    at = e1 + (DB - 1) * TD;
    e.at   = at;
    e.strb = v ^ exp_filt;
    e.filt = v;
    e.rise = (v ^ exp_filt) & v;
    e.fall = (v ^ exp_filt) & ~v;
    q.push_back(e);
    exp_filt   = v;
    bus.raw_in = v;
  endtask

  task automatic drain(input int budget);
    int g;
    g = 0;
    while (q.size() != 0 && g < budget) begin
      @(negedge clk);
      g++;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    int n0;
    int e1;
    bus.raw_in    = 8'h00;
    bus.rise_en   = 8'hFF;
    bus.fall_en   = 8'hFF;
    bus.event_clr = 8'h00;

    // 1: reset and idle
    #1 rst = 1'b1;
    #2;
    check("rst_filtered", {24'd0, bus.filtered}, 32'd0);
    check("rst_strobe", {24'd0, bus.change_strobe}, 32'd0);
    check("rst_rise", {24'd0, bus.rise_flag}, 32'd0);
    check("rst_fall", {24'd0, bus.fall_flag}, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_to(100);
    check("idle_filtered", {24'd0, bus.filtered}, 32'd0);
    check("idle_rise", {24'd0, bus.rise_flag}, 32'd0);
    check("idle_fall", {24'd0, bus.fall_flag}, 32'd0);
    check("idle_irq", {31'd0, bus.irq}, 32'd0);

    // 2: two-tick glitch on bit 0 must be rejected
    bus.raw_in = 8'h01;
    n0 = cyc;
    wait_to(n0 + 8);
    bus.raw_in = 8'h00;
    wait_to(cyc + 20);
    check("glitch_filtered", {24'd0, bus.filtered}, 32'd0);
    check("glitch_rise", {24'd0, bus.rise_flag}, 32'd0);

    // 3: clean rise on bit 3
    drive(8'h08, at);
    wait_to(at - 1);
    check("rise_before", {24'd0, bus.filtered}, 32'd0);
    wait_to(at);
    check("rise_filtered", {24'd0, bus.filtered}, 32'h08);
    check("rise_flag", {24'd0, bus.rise_flag}, 32'h08);
    check("rise_irq_lag", {31'd0, bus.irq}, 32'd0);
    wait_to(at + 1);
    check("rise_irq", {31'd0, bus.irq}, 32'd1);
    check("rise_strobe_off", {24'd0, bus.change_strobe}, 32'd0);
    drain(4);

    // 4: clear, then clear coinciding with a new rise
    bus.event_clr = 8'h08;
    wait_to(cyc + 1);
    bus.event_clr = 8'h00;
    check("clr_rise", {24'd0, bus.rise_flag}, 32'd0);
    check("clr_irq_lag", {31'd0, bus.irq}, 32'd1);
    wait_to(cyc + 1);
    check("clr_irq", {31'd0, bus.irq}, 32'd0);
    drive(8'h00, at);
    wait_to(at + 1);
    check("fall1_flag", {24'd0, bus.fall_flag}, 32'h08);
    check("fall1_irq", {31'd0, bus.irq}, 32'd1);
    bus.event_clr = 8'h08;
    wait_to(cyc + 1);
    bus.event_clr = 8'h00;
    wait_to(cyc + 1);
    check("clr2_fall", {24'd0, bus.fall_flag}, 32'd0);
    check("clr2_irq", {31'd0, bus.irq}, 32'd0);
    drive(8'h08, at);
    wait_to(at - 1);
    bus.event_clr = 8'h08;
    wait_to(at);
    bus.event_clr = 8'h00;
    check("set_wins", {24'd0, bus.rise_flag}, 32'h08);
    drain(4);

    // 5: masked fall, then enable it
    bus.event_clr = 8'h08;
    wait_to(cyc + 1);
    bus.event_clr = 8'h00;
    wait_to(cyc + 1);
    check("pre5_irq", {31'd0, bus.irq}, 32'd0);
    bus.fall_en = 8'h00;
    drive(8'h00, at);
    wait_to(at + 2);
    check("mask_fall_flag", {24'd0, bus.fall_flag}, 32'h08);
    check("mask_filtered", {24'd0, bus.filtered}, 32'd0);
    check("mask_irq", {31'd0, bus.irq}, 32'd0);
    bus.fall_en = 8'h08;
    wait_to(cyc + 1);
    check("unmask_irq", {31'd0, bus.irq}, 32'd1);
    check("unmask_fall_flag", {24'd0, bus.fall_flag}, 32'h08);
    drain(4);

    // 6: async reset mid-count, then quiet release
    bus.raw_in = 8'hFF;
    n0 = cyc;
    e1 = ((n0 + 3 + TD - 1) / TD) * TD;
    wait_to(e1 + 1);
    #2 rst = 1'b1;
    #1;
    check("arst_filtered", {24'd0, bus.filtered}, 32'd0);
    check("arst_rise", {24'd0, bus.rise_flag}, 32'd0);
    check("arst_fall", {24'd0, bus.fall_flag}, 32'd0);
    check("arst_irq", {31'd0, bus.irq}, 32'd0);
    bus.raw_in = 8'h00;
    exp_filt   = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_to(50);
    check("post_filtered", {24'd0, bus.filtered}, 32'd0);
    check("post_rise", {24'd0, bus.rise_flag}, 32'd0);
    check("post_fall", {24'd0, bus.fall_flag}, 32'd0);
    check("post_irq", {31'd0, bus.irq}, 32'd0);
    check("post_queue", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
